// File: rtl/accum_pingpong_bank.sv
// Ping-pong accumulator bank: one bank takes overwrite/accumulate row writes while the
// other is drained row by row over a valid/ready stream, clearing each row as it is read.
module accum_pingpong_bank #(
   parameter int NUM_COL    = 16,
   parameter int ACC_WIDTH  = 32,
   parameter int ADDR_WIDTH = 8,
   parameter int SAT_EN     = 1
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          acc_wr_en,
   input  logic                          acc_mode,
   input  logic [ADDR_WIDTH-1:0]         acc_addr,
   input  logic [NUM_COL*ACC_WIDTH-1:0]  in_psum_vec,
   input  logic                          swap_req,
   input  logic [ADDR_WIDTH:0]           drain_len,
   output logic                          swap_ack,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [NUM_COL*ACC_WIDTH-1:0]  out_vec,
   output logic [ADDR_WIDTH-1:0]         out_addr,
   output logic                          out_last,
   output logic                          busy,
   output logic                          sat_flag
);

   localparam int ROW_W = NUM_COL * ACC_WIDTH;
   localparam int DEPTH = 1 << ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0]   MAX_LEN = {1'b1, {ADDR_WIDTH{1'b0}}};
   localparam logic [ADDR_WIDTH:0]   LEN_ONE = 1;
   localparam logic [ADDR_WIDTH-1:0] PTR_ONE = 1;
   localparam logic signed [ACC_WIDTH-1:0] SMAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
   localparam logic signed [ACC_WIDTH-1:0] SMIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

   typedef enum logic {IDLE = 1'b0, DRAIN = 1'b1} state_t;

   state_t                state;
   logic                  cb;
   logic [ADDR_WIDTH-1:0] rd_ptr;
   logic [ADDR_WIDTH:0]   remaining;
   logic [ADDR_WIDTH:0]   len_clamped;
   logic [ROW_W-1:0]      bank [2][DEPTH];
   logic [ROW_W-1:0]      cur_row;
   logic [ROW_W-1:0]      wr_row;
   logic [ROW_W-1:0]      drain_row;
   logic [NUM_COL-1:0]    col_sat;
   logic                  sat_hit;
   logic                  swap_take;
   logic                  rd_fire;

   assign cur_row     = bank[cb][acc_addr];
   assign drain_row   = bank[~cb][rd_ptr];
   assign len_clamped = (drain_len > MAX_LEN) ? MAX_LEN : drain_len;
   assign sat_hit     = acc_wr_en && (|col_sat);
   assign swap_take   = (state == IDLE) && swap_req;
   assign rd_fire     = (state == DRAIN) && (!out_valid || out_ready) && (remaining != '0);

   // Overflow is detected from operand/result sign bits, so no extra guard bit is needed.
   for (genvar i = 0; i < NUM_COL; i++) begin : g_col
      logic signed [ACC_WIDTH-1:0] old_v;
      logic signed [ACC_WIDTH-1:0] in_v;
      logic signed [ACC_WIDTH-1:0] sum_v;
      logic signed [ACC_WIDTH-1:0] new_v;
      logic                        ovf;

      assign old_v = cur_row[i*ACC_WIDTH +: ACC_WIDTH];
      assign in_v  = in_psum_vec[i*ACC_WIDTH +: ACC_WIDTH];
      assign sum_v = old_v + in_v;
      assign ovf   = (old_v[ACC_WIDTH-1] == in_v[ACC_WIDTH-1]) &&
                     (sum_v[ACC_WIDTH-1] != old_v[ACC_WIDTH-1]);

      always_comb begin
         new_v = sum_v;
         if (!acc_mode)
            new_v = in_v;
         else if ((SAT_EN != 0) && ovf)
            new_v = old_v[ACC_WIDTH-1] ? SMIN : SMAX;
      end

      assign wr_row[i*ACC_WIDTH +: ACC_WIDTH] = new_v;
      assign col_sat[i] = (SAT_EN != 0) && acc_mode && ovf;
   end

   // Compute writes and drain clears always target opposite banks, so they never collide.
   always_ff @(posedge clk) begin
      if (acc_wr_en)
         bank[cb][acc_addr] <= wr_row;
      if (rd_fire)
         bank[~cb][rd_ptr] <= '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cb        <= 1'b0;
         rd_ptr    <= '0;
         remaining <= '0;
         swap_ack  <= 1'b0;
         out_valid <= 1'b0;
         out_vec   <= '0;
         out_addr  <= '0;
         out_last  <= 1'b0;
         busy      <= 1'b0;
         sat_flag  <= 1'b0;
      end else begin
         swap_ack <= 1'b0;
         // A saturation on the swap edge must survive the clear.
         if (sat_hit)
            sat_flag <= 1'b1;
         else if (swap_take)
            sat_flag <= 1'b0;

         case (state)
            IDLE: begin
               if (swap_req) begin
                  cb        <= ~cb;
                  remaining <= len_clamped;
                  rd_ptr    <= '0;
                  swap_ack  <= 1'b1;
                  if (len_clamped != '0) begin
                     state <= DRAIN;
                     busy  <= 1'b1;
                  end
               end
            end
            DRAIN: begin
               if (rd_fire) begin
                  out_vec   <= drain_row;
                  out_addr  <= rd_ptr;
                  out_valid <= 1'b1;
                  out_last  <= (remaining == LEN_ONE);
                  rd_ptr    <= rd_ptr + PTR_ONE;
                  remaining <= remaining - LEN_ONE;
               end else if (out_valid && out_ready && (remaining == '0)) begin
                  out_valid <= 1'b0;
                  out_last  <= 1'b0;
                  state     <= IDLE;
                  busy      <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_accum_pingpong_bank.sv
// Directed bench for accum_pingpong_bank: a saturating and a wrapping instance share stimulus,
// and a bank model feeds an expected-row queue that is popped on every drain handshake.
module tb_accum_pingpong_bank;

   localparam int NUM_COL = 16;
   localparam int ROW_W   = NUM_COL * 32;

   typedef struct {
      logic [ROW_W-1:0] ds;
      logic [ROW_W-1:0] dw;
      logic [7:0]       addr;
      logic             last;
   } exp_t;

   logic             clk;
   logic             rst_n;
   logic             acc_wr_en;
   logic             acc_mode;
   logic [7:0]       acc_addr;
   logic [ROW_W-1:0] in_psum_vec;
   logic             swap_req;
   logic [8:0]       drain_len;
   logic             out_ready;

   logic             swap_ack_s, out_valid_s, out_last_s, busy_s, sat_flag_s;
   logic [ROW_W-1:0] out_vec_s;
   logic [7:0]       out_addr_s;
   logic             swap_ack_w, out_valid_w, out_last_w, busy_w, sat_flag_w;
   logic [ROW_W-1:0] out_vec_w;
   logic [7:0]       out_addr_w;

   logic [ROW_W-1:0] ms [2][256];
   logic [ROW_W-1:0] mw [2][256];
   logic             mcb;
   exp_t             exp_q[$];
   int               n_assert = 0;
   int               n_fail = 0;

   accum_pingpong_bank #(.NUM_COL(NUM_COL), .ACC_WIDTH(32), .ADDR_WIDTH(8), .SAT_EN(1)) u_sat (
      .clk(clk), .rst_n(rst_n), .acc_wr_en(acc_wr_en), .acc_mode(acc_mode), .acc_addr(acc_addr),
      .in_psum_vec(in_psum_vec), .swap_req(swap_req), .drain_len(drain_len), .swap_ack(swap_ack_s),
      .out_valid(out_valid_s), .out_ready(out_ready), .out_vec(out_vec_s), .out_addr(out_addr_s),
      .out_last(out_last_s), .busy(busy_s), .sat_flag(sat_flag_s));

   accum_pingpong_bank #(.NUM_COL(NUM_COL), .ACC_WIDTH(32), .ADDR_WIDTH(8), .SAT_EN(0)) u_wrap (
      .clk(clk), .rst_n(rst_n), .acc_wr_en(acc_wr_en), .acc_mode(acc_mode), .acc_addr(acc_addr),
      .in_psum_vec(in_psum_vec), .swap_req(swap_req), .drain_len(drain_len), .swap_ack(swap_ack_w),
      .out_valid(out_valid_w), .out_ready(out_ready), .out_vec(out_vec_w), .out_addr(out_addr_w),
      .out_last(out_last_w), .busy(busy_w), .sat_flag(sat_flag_w));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic logic [31:0] satAdd(input logic [31:0] a, input logic [31:0] b);
      longint s;
      s = longint'($signed(a)) + longint'($signed(b));
      if (s > 64'sh0000_0000_7FFF_FFFF) return 32'h7FFF_FFFF;
      if (s < 64'shFFFF_FFFF_8000_0000) return 32'h8000_0000;
      return s[31:0];
   endfunction

   function automatic logic [ROW_W-1:0] makeVec(input logic [31:0] base, input logic [31:0] step);
      logic [ROW_W-1:0] v;
      for (int i = 0; i < NUM_COL; i++) v[i*32 +: 32] = base + step * 32'(i);
      return v;
   endfunction

   task automatic checkOutput(input string tag, input logic [ROW_W-1:0] observed,
                              input logic [ROW_W-1:0] expected);
      n_assert++;
      assert (observed === expected) else begin
         n_fail++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic modelWrite(input logic [7:0] addr, input logic mode, input logic [ROW_W-1:0] vec);
      for (int i = 0; i < NUM_COL; i++) begin
         if (!mode) begin
            ms[mcb][addr][i*32 +: 32] = vec[i*32 +: 32];
            mw[mcb][addr][i*32 +: 32] = vec[i*32 +: 32];
         end else begin
            ms[mcb][addr][i*32 +: 32] = satAdd(ms[mcb][addr][i*32 +: 32], vec[i*32 +: 32]);
            mw[mcb][addr][i*32 +: 32] = mw[mcb][addr][i*32 +: 32] + vec[i*32 +: 32];
         end
      end
   endtask

   task automatic modelSwap(input int len);
      int lenc;
      lenc = (len > 256) ? 256 : len;
      for (int r = 0; r < lenc; r++) begin
         exp_q.push_back('{ds: ms[mcb][r], dw: mw[mcb][r], addr: 8'(r), last: (r == lenc - 1)});
         ms[mcb][r] = '0;
         mw[mcb][r] = '0;
      end
      mcb = ~mcb;
   endtask

   task automatic applyStimulus(input logic [7:0] addr, input logic mode, input logic [ROW_W-1:0] vec);
      acc_wr_en   = 1'b1;
      acc_mode    = mode;
      acc_addr    = addr;
      in_psum_vec = vec;
      modelWrite(addr, mode, vec);
   endtask

   task automatic writeRow(input logic [7:0] addr, input logic mode, input logic [ROW_W-1:0] vec);
      applyStimulus(addr, mode, vec);
      @(negedge clk);
      acc_wr_en = 1'b0;
   endtask

   task automatic requestSwap(input int len, input bit wr, input logic [7:0] addr,
                              input logic [ROW_W-1:0] vec);
      drain_len = 9'(len);
      swap_req  = 1'b1;
      if (wr) applyStimulus(addr, 1'b1, vec);
      @(negedge clk);
      acc_wr_en = 1'b0;
      swap_req  = 1'b0;
      checkOutput("swap_ack", swap_ack_s, 1'b1);
      checkOutput("swap_ack_wrap", swap_ack_w, 1'b1);
      modelSwap(len);
   endtask

   task automatic checkIdle(input int cycles);
      for (int c = 0; c < cycles; c++) begin
         @(negedge clk);
         checkOutput("idle_valid", out_valid_s, 1'b0);
         checkOutput("idle_busy", busy_s, 1'b0);
         checkOutput("idle_ack", swap_ack_s, 1'b0);
      end
   endtask

   task automatic runDrain(input int ready_mode, input bit hold_swap, input bit conc);
      int  hs;
      int  exp_rows;
      bit  done;
      hs = 0;
      done = 1'b0;
      exp_rows = exp_q.size();
      for (int cyc = 0; cyc < 600 && !done; cyc++) begin
         acc_wr_en = 1'b0;
         if (exp_q.size() == 0) begin
            checkOutput("busy_fall", busy_s, 1'b0);
            checkOutput("valid_fall", out_valid_s, 1'b0);
            done = 1'b1;
         end else begin
            out_ready = (ready_mode == 0) || ((cyc % 3) == 0);
            if (conc && cyc < 6) applyStimulus(8'(cyc % 4), 1'b1, makeVec(32'(cyc + 1), 32'h100));
            checkOutput("busy", busy_s, 1'b1);
            if (cyc == 0) checkOutput("first_latency0", out_valid_s, 1'b0);
            if (cyc == 1) checkOutput("first_latency1", out_valid_s, 1'b1);
            if (hold_swap && cyc > 0) checkOutput("no_second_ack", swap_ack_s, 1'b0);
            if (out_valid_s) begin
               checkOutput("out_vec", out_vec_s, exp_q[0].ds);
               checkOutput("out_vec_wrap", out_vec_w, exp_q[0].dw);
               checkOutput("out_addr", out_addr_s, exp_q[0].addr);
               checkOutput("out_last", out_last_s, exp_q[0].last);
               if (out_ready) begin
                  void'(exp_q.pop_front());
                  hs++;
               end
            end
            @(negedge clk);
         end
      end
      acc_wr_en = 1'b0;
      out_ready = 1'b1;
      checkOutput("handshakes", hs, exp_rows);
   endtask

   initial begin
      bit found;
      rst_n = 1'b0; acc_wr_en = 1'b0; acc_mode = 1'b0; acc_addr = '0; in_psum_vec = '0;
      swap_req = 1'b0; drain_len = '0; out_ready = 1'b1; mcb = 1'b0;
      #1;
      checkOutput("rst_valid", out_valid_s, 1'b0);
      checkOutput("rst_vec", out_vec_s, '0);
      checkOutput("rst_addr", out_addr_s, '0);
      checkOutput("rst_last", out_last_s, 1'b0);
      checkOutput("rst_busy", busy_s, 1'b0);
      checkOutput("rst_ack", swap_ack_s, 1'b0);
      checkOutput("rst_sat", sat_flag_s, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;

      $display("[TB] initialise both banks, zero-length swap");
      for (int r = 0; r < 256; r++) writeRow(8'(r), 1'b0, '0);
      requestSwap(0, 1'b0, '0, '0);
      checkIdle(3);
      for (int r = 0; r < 256; r++) writeRow(8'(r), 1'b0, '0);

      $display("[TB] full 256-row drain");
      writeRow(8'd0, 1'b0, makeVec(32'd100, 32'd0));
      writeRow(8'd16, 1'b0, makeVec(32'd200, 32'd0));
      writeRow(8'd196, 1'b0, makeVec(32'd300, 32'd0));
      requestSwap(256, 1'b0, '0, '0);
      runDrain(0, 1'b0, 1'b0);

      $display("[TB] saturation versus wrap, write on swap edge");
      writeRow(8'd5, 1'b0, makeVec(32'h7FFF_FFF0, 32'd0));
      writeRow(8'd5, 1'b1, makeVec(32'h20, 32'd0));
      checkOutput("sat_set", sat_flag_s, 1'b1);
      checkOutput("wrap_no_sat", sat_flag_w, 1'b0);
      writeRow(8'd6, 1'b0, makeVec(32'h8000_0010, 32'd0));
      requestSwap(8, 1'b1, 8'd6, makeVec(32'hFFFF_FF00, 32'd0));
      checkOutput("sat_wins_clear", sat_flag_s, 1'b1);
      checkOutput("wrap_no_sat2", sat_flag_w, 1'b0);
      runDrain(0, 1'b0, 1'b0);

      $display("[TB] backpressure drain");
      for (int r = 0; r < 4; r++) writeRow(8'(r), 1'b0, makeVec(32'h100 * 32'(r + 1), 32'h11));
      requestSwap(4, 1'b0, '0, '0);
      checkOutput("sat_cleared", sat_flag_s, 1'b0);
      runDrain(1, 1'b0, 1'b0);

      $display("[TB] held swap request, clamped drain of cleared bank");
      for (int r = 0; r < 3; r++) writeRow(8'(r), 1'b0, makeVec(32'hA000 + 32'(r), 32'd1));
      requestSwap(3, 1'b0, '0, '0);
      swap_req = 1'b1;
      runDrain(0, 1'b1, 1'b0);
      requestSwap(300, 1'b0, '0, '0);
      runDrain(0, 1'b0, 1'b0);

      $display("[TB] concurrent accumulate during drain");
      for (int r = 0; r < 6; r++) writeRow(8'(r), 1'b0, makeVec(32'h5000 + 32'(r * 16), 32'd2));
      requestSwap(6, 1'b0, '0, '0);
      runDrain(0, 1'b0, 1'b1);
      requestSwap(4, 1'b0, '0, '0);
      runDrain(0, 1'b0, 1'b0);
      requestSwap(0, 1'b0, '0, '0);
      checkIdle(4);

      $display("[TB] reset mid-drain");
      for (int r = 0; r < 10; r++) writeRow(8'(r), 1'b0, makeVec(32'h1000 * 32'(r + 1), 32'd3));
      requestSwap(10, 1'b0, '0, '0);
      found = 1'b0;
      for (int c = 0; c < 40 && !found; c++) begin
         out_ready = 1'b1;
         if (out_valid_s && out_addr_s == 8'd3) begin
            found = 1'b1;
         end else begin
            if (out_valid_s) begin
               checkOutput("pre_rst_vec", out_vec_s, exp_q[0].ds);
               checkOutput("pre_rst_addr", out_addr_s, exp_q[0].addr);
               void'(exp_q.pop_front());
            end
            @(negedge clk);
         end
      end
      checkOutput("row3_reached", found, 1'b1);
      rst_n = 1'b0;
      #1;
      checkOutput("abort_valid", out_valid_s, 1'b0);
      checkOutput("abort_busy", busy_s, 1'b0);
      checkOutput("abort_addr", out_addr_s, '0);
      @(negedge clk);
      rst_n = 1'b1;
      mcb = 1'b0;
      exp_q.delete();
      checkIdle(12);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
